// File: rtl/div_sched_if.sv
// Request/response and divider-side signals of the divide sequencer.
// slave: the sequencer side; master: the requester and divider side.
interface div_sched_if #(
  parameter int N = 8
);
  logic         req;
  logic [3:0]   a;
  logic [3:0]   b;
  logic         busy;
  logic         done;
  logic         err;
  logic [7:0]   result;
  logic [N-1:0] div_a;
  logic [N-1:0] div_b;
  logic         div_strt;
  logic [N-1:0] div_q;
  logic [N-1:0] div_r;

  modport slave (
    input  req, a, b, div_q, div_r,
    output busy, done, err, result, div_a, div_b, div_strt
  );

  modport master (
    output req, a, b, div_q, div_r,
    input  busy, done, err, result, div_a, div_b, div_strt
  );
endinterface

// File: rtl/div_sched.sv
// Runs the shared divider twice (a/b, then rem*10/b) and rounds to a tenths result.
// Optional DIV_SCHED_FAST_EN skips the fractional stage when the integer remainder is zero.
module div_sched #(
  parameter int N       = 8,
  parameter int DIV_LAT = 9
) (
  input  logic        clk,
  input  logic        rst,
  div_sched_if.slave  bus
);
  localparam int CW = $clog2(DIV_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, INT_START, INT_WAIT, FRAC_START, FRAC_WAIT, ROUND, DONE, ERR
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     b_q, b_d;
  logic [3:0]     q_int_q, q_int_d;
  logic [3:0]     q_frac_q, q_frac_d;
  logic [3:0]     r_frac_q, r_frac_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           div_strt_q, div_strt_d;
  logic [7:0]     result_q, result_d;
  logic [N-1:0]   div_a_q, div_a_d;
  logic [N-1:0]   div_b_q, div_b_d;
  logic [3:0]     half;
  logic           rnd;
  logic           unused_div_bits;

  // Only the low nibble of the divider outputs can be significant for 4-bit operands.
  assign unused_div_bits = ^{bus.div_q[N-1:4], bus.div_r[N-1:4]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    q_int_d  = q_int_q;
    q_frac_d = q_frac_q;
    r_frac_d = r_frac_q;
    err_d    = err_q;
    result_d = result_q;
    div_a_d  = div_a_q;
    div_b_d  = div_b_q;
    half     = 4'd1;
    rnd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          b_d   = bus.b;
          err_d = 1'b0;
          if (bus.b == 4'd0) begin
            state_d  = ERR;
            err_d    = 1'b1;
            result_d = 8'hFF;
          end else begin
            state_d = INT_START;
            div_a_d = N'(bus.a);
            div_b_d = N'(bus.b);
          end
        end
      end
      INT_START: begin
        cnt_d   = CW'(DIV_LAT);
        state_d = INT_WAIT;
      end
      INT_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_int_d = bus.div_q[3:0];
`ifdef DIV_SCHED_FAST_EN
          if (bus.div_r[3:0] == 4'd0) begin
            q_frac_d = 4'd0;
            r_frac_d = 4'd0;
            state_d  = ROUND;
          end else
`endif
          begin
            // Operand is registered on entry so it is already stable during FRAC_START.
            div_a_d = N'({4'd0, bus.div_r[3:0]} * 8'd10);
            state_d = FRAC_START;
          end
        end
      end
      FRAC_START: begin
        cnt_d   = CW'(DIV_LAT);
        state_d = FRAC_WAIT;
      end
      FRAC_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_frac_d = bus.div_q[3:0];
          r_frac_d = bus.div_r[3:0];
          state_d  = ROUND;
        end
      end
      ROUND: begin
        half     = (b_q == 4'd1) ? 4'd1 : (b_q >> 1);
        rnd      = (r_frac_q >= half);
        result_d = {4'd0, q_int_q} * 8'd10 + {4'd0, q_frac_q} + {7'd0, rnd};
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE) || (state_d == ERR);
    div_strt_d = (state_d == INT_START) || (state_d == FRAC_START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      b_q        <= '0;
      q_int_q    <= '0;
      q_frac_q   <= '0;
      r_frac_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      div_strt_q <= 1'b0;
      result_q   <= 8'h00;
      div_a_q    <= '0;
      div_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      b_q        <= b_d;
      q_int_q    <= q_int_d;
      q_frac_q   <= q_frac_d;
      r_frac_q   <= r_frac_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      div_strt_q <= div_strt_d;
      result_q   <= result_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.result   = result_q;
  assign bus.div_a    = div_a_q;
  assign bus.div_b    = div_b_q;
  assign bus.div_strt = div_strt_q;
endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: divider model, cycle-level reference model, directed literal cases and random traffic.
module tb_div_sched;
  localparam int N = 8;
  localparam int L = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  div_sched_if #(.N(N)) bus();
  div_sched #(.N(N), .DIV_LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Divider: result valid only in the cycle DIV_LAT after the start cycle, noise otherwise.
  int           dv_cnt = -1;
  logic [N-1:0] dv_a, dv_b;
  always @(posedge clk) begin
    #1;
    if (dv_cnt >= 0) dv_cnt--;
    if (bus.div_strt === 1'b1) begin
      dv_cnt = L;
      dv_a   = bus.div_a;
      dv_b   = bus.div_b;
    end
    if (dv_cnt == 0 && dv_b != 0) begin
      bus.div_q = dv_a / dv_b;
      bus.div_r = dv_a % dv_b;
    end else begin
      bus.div_q = N'($urandom);
      bus.div_r = N'($urandom);
    end
  end

  function automatic logic [7:0] ref_tenths(input int a, input int b);
    int qi, ri, qf, rf, half;
    qi   = a / b;
    ri   = a % b;
    qf   = (ri * 10) / b;
    rf   = (ri * 10) % b;
    half = (b == 1) ? 1 : b / 2;
    return 8'(qi * 10 + qf + ((rf >= half) ? 1 : 0));
  endfunction

  // Reference: position k within a job of known length decides every output.
  int         m_k = 0, m_len = 0, ia, ib;
  logic       m_busy = 0, m_done = 0, m_err = 0, m_strt = 0, m_exp_err = 0;
  logic [7:0] m_res = 0, m_exp_res = 0, m_op1a = 0, m_op2a = 0, m_opa = 0;
  logic [3:0] m_b = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = 0; m_busy = 0; m_done = 0; m_err = 0; m_res = 0; m_strt = 0;
    end else begin
      if (m_k == 0) begin
        if (bus.req === 1'b1) begin
          ia = int'(bus.a);
          ib = int'(bus.b);
          m_k = 1; m_err = 0; m_b = bus.b;
          if (ib == 0) begin
            m_len = 1; m_exp_res = 8'hFF; m_exp_err = 1;
          end else begin
            m_len = 2 * L + 4; m_exp_res = ref_tenths(ia, ib); m_exp_err = 0;
            m_op1a = 8'(ia); m_op2a = 8'((ia % ib) * 10);
          end
        end
      end else if (m_k == m_len) m_k = 0;
      else m_k++;
      m_busy = (m_k != 0);
      m_done = m_busy && (m_k == m_len);
      if (m_done) begin m_res = m_exp_res; m_err = m_exp_err; end
      m_strt = m_busy && (m_len > 1) && (m_k == 1 || m_k == L + 2);
      m_opa  = (m_k == 1) ? m_op1a : m_op2a;
    end
  end

  always @(negedge clk) begin
    chk("busy", bus.busy, m_busy);
    chk("done", bus.done, m_done);
    chk("err", bus.err, m_err);
    chk("result", bus.result, m_res);
    chk("div_strt", bus.div_strt, m_strt);
    if (m_strt) begin
      chk("div_a", bus.div_a, m_opa);
      chk("div_b", bus.div_b, m_b);
    end
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) chk("idle_timeout", bus.busy, 0);
  endtask

  task automatic run_lit(input string nm, input logic [3:0] a, input logic [3:0] b,
                         input int exp_res, input int exp_err, input int exp_lat,
                         input int exp_strt, input int exp_op2);
    int lat, strts;
    logic [N-1:0] op2;
    wait_idle();
    bus.req = 1'b1; bus.a = a; bus.b = b;
    lat = 0; strts = 0; op2 = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin bus.req = 1'b0; bus.a = 4'($urandom); bus.b = 4'($urandom); end
      if (bus.div_strt === 1'b1) begin strts++; if (strts == 2) op2 = bus.div_a; end
    end while (bus.done !== 1'b1 && lat < 200);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " result"}, bus.result, exp_res);
    chk({nm, " err"}, bus.err, exp_err);
    chk({nm, " strts"}, strts, exp_strt);
    if (exp_op2 >= 0) chk({nm, " frac div_a"}, op2, exp_op2);
  endtask

  initial begin
    int strts, dones;
    bus.req = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", bus.busy, 0);
    chk("rst result", bus.result, 0);
    chk("rst div_a", bus.div_a, 0);
    chk("rst div_strt", bus.div_strt, 0);
    #2 rst = 1'b0;

    run_lit("7/2", 4'd7, 4'd2, 35, 0, 22, 2, 10);
    run_lit("2/3", 4'd2, 4'd3, 7, 0, 22, 2, 20);
    run_lit("15/1", 4'd15, 4'd1, 150, 0, 22, 2, 0);
    run_lit("0/5", 4'd0, 4'd5, 0, 0, 22, 2, 0);
    run_lit("9/0", 4'd9, 4'd0, 255, 1, 1, 0, -1);
    repeat (2) @(negedge clk);
    chk("err held", bus.err, 1);
    run_lit("4/2", 4'd4, 4'd2, 20, 0, 22, 2, 0);

    // req chatter throughout the fractional wait must not start anything.
    wait_idle();
    bus.req = 1'b1; bus.a = 4'd11; bus.b = 4'd3;
    strts = 0; dones = 0;
    for (int k = 1; k <= 2 * L + 8; k++) begin
      @(negedge clk);
      if (bus.div_strt === 1'b1) strts++;
      if (bus.done === 1'b1) dones++;
      bus.req = (k >= L + 3 && k <= 2 * L + 2) ? 1'(k % 2) : 1'b0;
      bus.a = 4'($urandom); bus.b = 4'($urandom);
    end
    chk("chatter dones", dones, 1);
    chk("chatter strts", strts, 2);
    chk("chatter result", bus.result, 37);

    // Reset in the middle of the integer wait.
    wait_idle();
    bus.req = 1'b1; bus.a = 4'd9; bus.b = 4'd4;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst result", bus.result, 0);
    chk("midrst div_strt", bus.div_strt, 0);
    chk("midrst done", bus.done, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_lit("9/4", 4'd9, 4'd4, 23, 0, 22, 2, 10);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.req = ($urandom_range(0, 3) == 0);
      bus.a   = 4'($urandom);
      bus.b   = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom);
      if (i % 500 == 250) begin #2 rst = 1'b1; #2 rst = 1'b0; end
    end
    bus.req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
